conversor_dec_bin: RTL and testbench

Sequential decimal-to-binary converter for the calculator datapath. It accepts a packed BCD word of N_DIGITS decimal digits, such as the operand assembled from keypad entry. It returns the equivalent unsigned binary value by running the reverse double-dabble algorithm (shift-right / subtract-3), one bit per clock. It is the inverse of the binary-to-BCD display path and feeds binary operands into the ALU under a valid/ready handshake on both sides.

---
 rtl/conversor_dec_bin_pkg.sv | 19 +
 rtl/conversor_dec_bin_adj.sv | 9 +
 rtl/conversor_dec_bin.sv | 137 +++++++++++++
 tb/tb_conversor_dec_bin.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conversor_dec_bin_pkg.sv
// Shared constants, state encoding and sizing helper for the BCD-to-binary converter.
package conversor_dec_bin_pkg;

  localparam int N_DIGITS_DEF = 6;
  localparam int BIN_W_DEF    = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

endpackage

// File: rtl/conversor_dec_bin_adj.sv
// One-nibble correction step of reverse double-dabble: subtract 3 when the nibble is 8 or more.
module bcd_nibble_adj (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd8) ? (nib - 4'd3) : nib;

endmodule

// File: rtl/conversor_dec_bin.sv
// Sequential packed-BCD to binary converter, one bit per clock, valid/ready on both sides.
// Optional nibble validity check enabled by defining CONVERSOR_DEC_BIN_ERR_CHECK_EN.
module conversor_dec_bin
  import conversor_dec_bin_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int BIN_W    = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state, state_nx;
  logic [BCD_W-1:0]   bcd_reg, bcd_nx;
  logic [BIN_W-1:0]   bin_reg, bin_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [BIN_W-1:0]   bin_out_nx;
  logic               err_q, err_nx;
  logic               skip, skip_nx;
  logic               bad_in;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;

  assign shifted = {bcd_reg, bin_reg} >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nib (shifted[BIN_W + 4*g +: 4]),
      .adj (bcd_adj[4*g +: 4])
    );
  end

`ifdef CONVERSOR_DEC_BIN_ERR_CHECK_EN
  function automatic logic has_bad_nibble(input logic [BCD_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in = has_bad_nibble(bcd_in);
`else
  assign bad_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err_q   <= 1'b0;
      skip    <= 1'b0;
    end else begin
      state   <= state_nx;
      bcd_reg <= bcd_nx;
      bin_reg <= bin_nx;
      cnt     <= cnt_nx;
      bin_out <= bin_out_nx;
      err_q   <= err_nx;
      skip    <= skip_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bcd_nx     = bcd_reg;
    bin_nx     = bin_reg;
    cnt_nx     = cnt;
    bin_out_nx = bin_out;
    err_nx     = err_q;
    skip_nx    = skip;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = BUSY;
          bcd_nx   = bcd_in;
          bin_nx   = '0;
          cnt_nx   = '0;
          skip_nx  = bad_in;
        end
      end
      BUSY: begin
        if (skip) begin
          // Invalid word: report it after a single cycle without converting.
          state_nx   = DONE;
          bin_out_nx = '0;
          err_nx     = 1'b1;
          skip_nx    = 1'b0;
          bcd_nx     = '0;
        end else begin
          bcd_nx = bcd_adj;
          bin_nx = shifted[BIN_W-1:0];
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nx   = DONE;
            bin_out_nx = shifted[BIN_W-1:0];
            err_nx     = 1'b0;
            cnt_nx     = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
          err_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef CONVERSOR_DEC_BIN_ERR_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conversor_dec_bin.sv
// Self-checking bench for conversor_dec_bin: vector table, randomized words vs. decimal model, corner sequences.
module tb_conversor_dec_bin;

  localparam int N_DIGITS = 6;
  localparam int BIN_W    = 20;
  localparam int LAT      = BIN_W + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  out_valid;
  logic                  out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conversor_dec_bin #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [23:0] bcd;
    logic [19:0] bin;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Decimal value of a packed BCD word, straight from positional arithmetic.
  function automatic int bcd_value(input logic [23:0] w);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < N_DIGITS; i++) begin
      v += int'(w[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  // Called at a negedge after the acceptance edge; lat counts edges from acceptance to DONE inclusive.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_word(input logic [23:0] w, output logic [19:0] res,
                          output logic e, output int lat);
    bcd_in   = w;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    res = bin_out;
    e   = err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        vecs[6];
  logic [19:0] res;
  logic        e;
  int          lat;
  logic [23:0] w;
  logic [19:0] held;

  initial begin
    vecs[0] = '{24'h000000, 20'h00000};
    vecs[1] = '{24'h012345, 20'h03039};
    vecs[2] = '{24'h999999, 20'hF423F};
    vecs[3] = '{24'h000042, 20'h0002A};
    vecs[4] = '{24'h000001, 20'h00001};
    vecs[5] = '{24'h100000, 20'h186A0};

    rst_n     = 1'b0;
    bcd_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].bcd, res, e, lat);
      check($sformatf("vec%0d_bin", i), 32'(res), 32'(vecs[i].bin));
      check($sformatf("vec%0d_err", i), 32'(e), 32'd0);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
      release_out();
      check($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result holds while a new word waits at the input.
    run_word(24'h000777, res, e, lat);
    check("bp_first_bin", 32'(res), 32'd777);
    bcd_in   = 24'h000555;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold_bin%0d", k), 32'(bin_out), 32'd777);
      check($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp_out_valid%0d", k), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    wait_done(lat);
    check("bp_second_bin", 32'(bin_out), 32'd555);
    check("bp_second_lat", 32'(lat), 32'(LAT));
    release_out();

    // Invalid nibble handling depends on the build configuration.
    run_word(24'h00A000, res, e, lat);
`ifdef CONVERSOR_DEC_BIN_ERR_CHECK_EN
    check("bad_err", 32'(e), 32'd1);
    check("bad_bin", 32'(res), 32'd0);
    check("bad_lat", 32'(lat), 32'd2);
`else
    check("bad_err", 32'(e), 32'd0);
    check("bad_lat", 32'(lat), 32'(LAT));
`endif
    release_out();
    check("bad_err_cleared", 32'(err), 32'd0);

    // Reset in the middle of a conversion.
    bcd_in   = 24'h999999;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_word(24'h000042, res, e, lat);
    check("postrst_bin", 32'(res), 32'h2A);
    check("postrst_lat", 32'(lat), 32'(LAT));
    release_out();

    // Random valid words against the decimal model, with random consumer stalls.
    for (int n = 0; n < 30; n++) begin
      w = '0;
      for (int d = 0; d < N_DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
      run_word(w, res, e, lat);
      check($sformatf("rnd%0d_bin w=%06h", n, w), 32'(res), 32'(bcd_value(w)));
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(LAT));
      held = res;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("rnd%0d_hold", n), 32'(bin_out), 32'(held));
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
